// File: rtl/register_write_arbiter_pkg.sv
// Shared encodings for the register-write arbiter slice: write patterns and pointer values.
// Pure constants, no logic; imported by the arbiter, its scoreboard and the bench.
// Pattern codes must match the register file's write_pattern decoding.
package register_write_arbiter_pkg;

  localparam int REGWR_PAT_W = 3;

  // Register file write_pattern encodings
  localparam logic [REGWR_PAT_W-1:0] REGISTER_WRITE_WORD          = 3'b001;
  localparam logic [REGWR_PAT_W-1:0] REGISTER_WRITE_BYTE_UNSIGNED = 3'b100;

  // Round-robin pointer: names the requester that wins the next contended cycle
  localparam logic REGWR_GRANT_ALU = 1'b0;
  localparam logic REGWR_GRANT_LSU = 1'b1;

endpackage

// File: rtl/register_write_arbiter_load_scoreboard.sv
// Load scoreboard: one busy bit per register, set on load issue, cleared on LSU writeback.
// Latency: set/clear visible one cycle after the request; read ports are combinational.
// No backpressure; built only when REGWR_SCOREBOARD_EN is defined.
module load_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_rd,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_rd,
  input  logic [ADDR_W-1:0]      rd_a,
  input  logic [ADDR_W-1:0]      rd_b,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic [(1<<ADDR_W)-1:0] busy
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clear first so a same-cycle set (newer load) wins; x0 never busy
  always_comb begin
    busy_d = busy_q;
    if (clr_en)
      busy_d[clr_rd] = 1'b0;
    if (set_en && (set_rd != '0))
      busy_d[set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_a = busy_q[rd_a];
  assign busy_b = busy_q[rd_b];
  assign busy   = busy_q;

endmodule

// File: rtl/register_write_arbiter.sv
// Shares the register file write port between ALU writeback and LSU load results, round-robin.
// Latency: grant in cycle N drives rf_wr_* in cycle N+1 for one cycle; one write per cycle.
// Backpressure: ready is combinational from valids/pointer/scoreboard; REGWR_SCOREBOARD_EN adds load hazards.
module register_write_arbiter
  import register_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int PAT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic [PAT_W-1:0]  lsu_pattern,
  input  logic              load_issue,
  input  logic [ADDR_W-1:0] load_issue_rd,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic              hazard_stall,
  output logic              rf_wr_enable,
  output logic [ADDR_W-1:0] rf_wr_address,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [PAT_W-1:0]  rf_write_pattern
);

  logic rr_ptr;
  logic alu_waw;
  logic alu_elig;
  logic contended;
  logic grant_alu;
  logic grant_lsu;

`ifdef REGWR_SCOREBOARD_EN
  logic                   busy_a;
  logic                   busy_b;
  logic [(1<<ADDR_W)-1:0] busy;

  load_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_load_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (load_issue),
    .set_rd (load_issue_rd),
    .clr_en (grant_lsu),
    .clr_rd (lsu_rd),
    .rd_a   (src_a),
    .rd_b   (src_b),
    .busy_a (busy_a),
    .busy_b (busy_b),
    .busy   (busy)
  );

  assign hazard_stall = busy_a | busy_b;
  // An ALU write to a register with a load in flight would be overwritten out of order
  assign alu_waw      = busy[alu_rd];
`else
  logic unused_sb_inputs;

  assign unused_sb_inputs = ^{load_issue, load_issue_rd, src_a, src_b};
  assign hazard_stall     = 1'b0;
  assign alu_waw          = 1'b0;
`endif

  // Arbitration: a lone eligible requester wins; on contention the pointer holder wins
  always_comb begin
    alu_elig  = alu_valid && !alu_waw;
    contended = alu_elig && lsu_valid;
    grant_lsu = lsu_valid && (!alu_elig || (rr_ptr == REGWR_GRANT_LSU));
    grant_alu = alu_elig  && (!lsu_valid || (rr_ptr == REGWR_GRANT_ALU));
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  // Round-robin pointer moves only when both requesters actually competed
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= REGWR_GRANT_LSU;
    else if (contended)
      rr_ptr <= grant_lsu ? REGWR_GRANT_ALU : REGWR_GRANT_LSU;
  end

  // Output register: granted write appears for one cycle; writes to x0 are swallowed
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_enable     <= 1'b0;
      rf_wr_address    <= '0;
      rf_wr_data       <= '0;
      rf_write_pattern <= REGISTER_WRITE_WORD;
    end else if (grant_lsu) begin
      rf_wr_enable     <= (lsu_rd != '0);
      rf_wr_address    <= lsu_rd;
      rf_wr_data       <= lsu_data;
      rf_write_pattern <= lsu_pattern;
    end else if (grant_alu) begin
      rf_wr_enable     <= (alu_rd != '0);
      rf_wr_address    <= alu_rd;
      rf_wr_data       <= alu_data;
      rf_write_pattern <= REGISTER_WRITE_WORD;
    end else begin
      rf_wr_enable     <= 1'b0;
    end
  end

endmodule
